// File: rtl/cpu_run_controller_if.sv
// Bundles the run-controller's button, syscall-decode, register-file and
// display signals so the CPU top and the bench connect through one port.
interface cpu_run_controller_if #(
    parameter int CNT_W = 32
);
    logic             go;
    logic             step_mode;
    logic             syscall;
    logic [31:0]      v0;
    logic [31:0]      a0;
    logic             pc_en;
    logic             halted;
    logic [31:0]      disp_data;
    logic             disp_valid;
    logic [CNT_W-1:0] instr_cnt;

    // Board/CPU side: drives requests, observes the controller
    modport master (
        output go, step_mode, syscall, v0, a0,
        input  pc_en, halted, disp_data, disp_valid, instr_cnt
    );

    // Controller side
    modport slave (
        input  go, step_mode, syscall, v0, a0,
        output pc_en, halted, disp_data, disp_valid, instr_cnt
    );
endinterface

// File: rtl/cpu_run_controller.sv
// Run/step/halt sequencer for the single-cycle MIPS CPU.
// pc_en is deliberately combinational (Mealy) so an exit syscall is blocked
// in the same cycle it is decoded; everything else is registered.
module cpu_run_controller #(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    cpu_run_controller_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    localparam logic [31:0] SVC_PRINT_INT = 32'd1;
    localparam logic [31:0] SVC_PRINT_HEX = 32'd34;
    localparam logic [31:0] SVC_EXIT      = 32'd10;

    state_t           state_r;
    logic             halted_r;
    logic [31:0]      disp_data_r;
    logic             disp_valid_r;
    logic [CNT_W-1:0] instr_cnt_r;

    logic active_s;
    logic exit_req_s;
    logic pc_en_s;
    logic print_req_s;
    logic cnt_full_s;

    // Decode commit enable, exit and print requests for the current instruction
    always_comb begin
        active_s    = (state_r == ST_RUN) || (state_r == ST_STEP);
        exit_req_s  = active_s && bus.syscall && (bus.v0 == SVC_EXIT);
        pc_en_s     = active_s && !exit_req_s;
        print_req_s = pc_en_s && bus.syscall &&
                      ((bus.v0 == SVC_PRINT_INT) || (bus.v0 == SVC_PRINT_HEX));
        cnt_full_s  = (instr_cnt_r == {CNT_W{1'b1}});
    end

    // Sequencer FSM with registered status, display and commit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            halted_r     <= 1'b0;
            disp_data_r  <= 32'd0;
            disp_valid_r <= 1'b0;
            instr_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            // Print pulse lasts one cycle unless another print commits
            if (print_req_s) begin
                disp_data_r  <= bus.a0;
                disp_valid_r <= 1'b1;
            end else begin
                disp_valid_r <= 1'b0;
            end

            // Counter saturates so the display never wraps back to zero
            if (pc_en_s && !cnt_full_s) begin
                instr_cnt_r <= instr_cnt_r + CNT_W'(1);
            end

            case (state_r)
                ST_IDLE: begin
                    if (bus.go && !bus.step_mode) begin
                        state_r <= ST_RUN;
                    end else if (bus.go && bus.step_mode) begin
                        state_r <= ST_STEP;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // Exit outranks a simultaneous pause request
                    if (exit_req_s) begin
                        state_r  <= ST_HALT;
                        halted_r <= 1'b1;
                    end else if (bus.go || bus.step_mode) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_STEP: begin
                    if (exit_req_s) begin
                        state_r  <= ST_HALT;
                        halted_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_HALT: begin
                    state_r  <= ST_HALT;
                    halted_r <= 1'b1;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_en      = pc_en_s;
    assign bus.halted     = halted_r;
    assign bus.disp_data  = disp_data_r;
    assign bus.disp_valid = disp_valid_r;
    assign bus.instr_cnt  = instr_cnt_r;
endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: start, pause, single step, print
// services, exit/halt priority, async reset in HALT and counter saturation.
module tb_cpu_run_controller;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    cpu_run_controller_if #(.CNT_W(32)) bus ();
    cpu_run_controller_if #(.CNT_W(4))  bus4 ();

    cpu_run_controller #(.CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cpu_run_controller #(.CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    // 100 MHz free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; registered outputs are settled on return
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        bus.go = 1'b0;  bus.step_mode = 1'b0; bus.syscall = 1'b0;
        bus.v0 = 32'd0; bus.a0 = 32'd0;
        bus4.go = 1'b0; bus4.step_mode = 1'b0; bus4.syscall = 1'b0;
        bus4.v0 = 32'd0; bus4.a0 = 32'd0;
        cyc(); cyc();
        #1;
        check("rst_pc_en",      32'(bus.pc_en),      32'd0);
        check("rst_halted",     32'(bus.halted),     32'd0);
        check("rst_disp_data",  bus.disp_data,       32'd0);
        check("rst_disp_valid", 32'(bus.disp_valid), 32'd0);
        check("rst_instr_cnt",  bus.instr_cnt,       32'd0);
        rst = 1'b0;
        cyc();

        // Start in free-run mode
        bus.go = 1'b1;
        cyc();
        bus.go = 1'b0;
        #1;
        check("run_pc_en_first", 32'(bus.pc_en), 32'd1);
        check("run_cnt_first",   bus.instr_cnt,  32'd0);
        for (int i = 0; i < 5; i++) cyc();
        #1;
        check("run_cnt_5",   bus.instr_cnt,     32'd5);
        check("run_halted0", 32'(bus.halted),   32'd0);

        // Pause: the go cycle still commits, then IDLE
        bus.go = 1'b1;
        #1;
        check("pause_pc_en_go", 32'(bus.pc_en), 32'd1);
        cyc();
        bus.go = 1'b0;
        #1;
        check("pause_pc_en_idle", 32'(bus.pc_en), 32'd0);
        check("pause_cnt",        bus.instr_cnt,  32'd6);
        cyc();
        check("pause_cnt_hold",   bus.instr_cnt,  32'd6);

        // Three single steps, ten cycles apart
        bus.step_mode = 1'b1;
        for (int s = 0; s < 3; s++) begin
            bus.go = 1'b1;
            cyc();
            bus.go = 1'b0;
            #1;
            pulses = 0;
            for (int k = 0; k < 10; k++) begin
                if (bus.pc_en) pulses++;
                cyc();
            end
            check("step_one_pulse", 32'(pulses), 32'd1);
            check("step_idle_pc_en", 32'(bus.pc_en), 32'd0);
        end
        check("step_cnt_3", bus.instr_cnt, 32'd9);

        // step_mode raised while running: commit then drop to IDLE
        bus.step_mode = 1'b0;
        bus.go = 1'b1;
        cyc();
        bus.go = 1'b0;
        cyc();
        bus.step_mode = 1'b1;
        #1;
        check("sm_run_pc_en", 32'(bus.pc_en), 32'd1);
        cyc();
        #1;
        check("sm_idle_pc_en", 32'(bus.pc_en), 32'd0);
        check("sm_cnt",        bus.instr_cnt,  32'd11);
        bus.step_mode = 1'b0;

        // Print services in RUN
        bus.go = 1'b1;
        cyc();
        bus.go = 1'b0;
        bus.syscall = 1'b1; bus.v0 = 32'd34; bus.a0 = 32'h0000_1234;
        cyc();
        check("prt_hex_data",  bus.disp_data,       32'h0000_1234);
        check("prt_hex_valid", 32'(bus.disp_valid), 32'd1);
        bus.v0 = 32'd5; bus.a0 = 32'hdead_beef;
        cyc();
        check("prt_nop_valid", 32'(bus.disp_valid), 32'd0);
        check("prt_nop_data",  bus.disp_data,       32'h0000_1234);
        bus.v0 = 32'd1; bus.a0 = 32'h0000_5678;
        cyc();
        check("prt_int_data",  bus.disp_data,       32'h0000_5678);
        check("prt_int_valid", 32'(bus.disp_valid), 32'd1);
        bus.v0 = 32'd34; bus.a0 = 32'h0000_9abc;
        cyc();
        check("prt_b2b_data",  bus.disp_data,       32'h0000_9abc);
        check("prt_b2b_valid", 32'(bus.disp_valid), 32'd1);
        bus.syscall = 1'b0;
        cyc();
        check("prt_end_valid", 32'(bus.disp_valid), 32'd0);
        check("prt_end_data",  bus.disp_data,       32'h0000_9abc);
        check("prt_cnt",       bus.instr_cnt,       32'd16);

        // go together with exit syscall: HALT wins
        bus.syscall = 1'b1; bus.v0 = 32'd10; bus.go = 1'b1;
        #1;
        check("exit_pc_en", 32'(bus.pc_en), 32'd0);
        cyc();
        bus.go = 1'b0; bus.syscall = 1'b0; bus.v0 = 32'd0;
        #1;
        check("exit_halted",   32'(bus.halted), 32'd1);
        check("exit_pc_en_nx", 32'(bus.pc_en),  32'd0);
        check("exit_cnt",      bus.instr_cnt,   32'd16);
        bus.go = 1'b1; bus.step_mode = 1'b1;
        cyc();
        bus.go = 1'b0;
        cyc();
        check("halt_pc_en", 32'(bus.pc_en),  32'd0);
        check("halt_stay",  32'(bus.halted), 32'd1);
        check("halt_cnt",   bus.instr_cnt,   32'd16);

        // Asynchronous reset mid-cycle while halted
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_pc_en",      32'(bus.pc_en),      32'd0);
        check("arst_halted",     32'(bus.halted),     32'd0);
        check("arst_disp_data",  bus.disp_data,       32'd0);
        check("arst_disp_valid", 32'(bus.disp_valid), 32'd0);
        check("arst_cnt",        bus.instr_cnt,       32'd0);
        cyc();
        rst = 1'b0;

        // Exit syscall during a single step
        bus.step_mode = 1'b1; bus.go = 1'b1;
        cyc();
        bus.go = 1'b0;
        bus.syscall = 1'b1; bus.v0 = 32'd10;
        #1;
        check("step_exit_pc_en", 32'(bus.pc_en), 32'd0);
        cyc();
        bus.syscall = 1'b0;
        check("step_exit_halted", 32'(bus.halted), 32'd1);
        check("step_exit_cnt",    bus.instr_cnt,   32'd0);

        // 4-bit counter saturation
        bus4.go = 1'b1;
        cyc();
        bus4.go = 1'b0;
        for (int i = 0; i < 14; i++) cyc();
        check("sat_cnt_14", 32'(bus4.instr_cnt), 32'd14);
        for (int i = 0; i < 6; i++) cyc();
        check("sat_cnt_15", 32'(bus4.instr_cnt), 32'd15);
        check("sat_pc_en",  32'(bus4.pc_en),     32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
